// File: rtl/nibble_serial_adder.sv
// Purpose: serial adder/subtractor, one 4-bit carry-lookahead group per clock.
// Latency: WIDTH/4 cycles in RUN after the start edge, then a one-cycle done pulse.
// Backpressure: none; start is ignored while busy, so callers wait for done.
//
// Ports:
//   Clk, Reset      - clock and synchronous active-high reset
//   start, sub, cin - operation request, subtract select, add-mode carry-in
//   A, B            - operands, captured only on the accepting edge
//   busy, done      - state decodes (RUN / DONE)
//   Sum, Cout, ovf  - registered result, carry out, two's-complement overflow
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;

    logic [3:0] a_nib, b_nib, p, g, c, nib_sum;
    logic       grp_p, grp_g, carry_nxt, ovf_nxt;

    // One lookahead group on the nibble selected by idx.
    always_comb begin
        a_nib = opA[{idx, 2'b00} +: 4];
        b_nib = opB[{idx, 2'b00} +: 4];
        p     = a_nib ^ b_nib;
        g     = a_nib & b_nib;

        c[0] = carry;
        c[1] = g[0] | (p[0] & carry);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);

        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

        carry_nxt = grp_g | (grp_p & carry);
        nib_sum   = p ^ c;

        // a^b^sum at the MSB recovers the carry into the MSB; XOR with the
        // carry out gives signed overflow. Only meaningful on the last nibble.
        ovf_nxt = carry_nxt ^ (opA[WIDTH-1] ^ opB[WIDTH-1] ^ nib_sum[3]);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            opA   <= '0;
            opB   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opA   <= A;
                        // Subtract as A + ~B + 1; cin is irrelevant then.
                        opB   <= sub ? ~B : B;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        Sum   <= '0;
                        Cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    Sum[{idx, 2'b00} +: 4] <= nib_sum;
                    carry                  <= carry_nxt;
                    if (idx == LAST) begin
                        // idx stays at LAST; it only returns to 0 on acceptance.
                        Cout  <= carry_nxt;
                        ovf   <= ovf_nxt;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Purpose: directed scoreboard bench for nibble_serial_adder (WIDTH=16).
// Latency: expects done exactly 4 busy cycles after each accepted start.
// Backpressure: stimulus waits on done with a bounded cycle budget.
module tb_nibble_serial_adder;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic        Cout;
    logic        ovf;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .ovf   (ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int pass_cnt = 0;
    int total    = 0;

    // Expected {Sum, Cout, ovf} per accepted operation, in issue order.
    logic [17:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge Clk) begin
        if (busy === 1'b1 && done === 1'b1)
            chk("busy_done_exclusive", 32'd1, 32'd0);
        if (Reset === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {14'd0, Sum, Cout, ovf}, 32'hDEAD);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk("result_sum",  {16'd0, Sum}, {16'd0, e[17:2]});
                chk("result_cout", {31'd0, Cout}, {31'd0, e[1]});
                chk("result_ovf",  {31'd0, ovf},  {31'd0, e[0]});
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb);
        A = a; B = b; cin = ci; sub = sb; start = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) nbusy++;
            @(negedge Clk);
        end
    endtask

    task automatic run_op(input string name,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
        int nb;
        bit got;
        issue(a, b, ci, sb);
        exp_q.push_back({es, ec, eo});
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        wait_done(nb, got);
        chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_latency"}, nb, 32'd4);
    endtask

    initial begin
        int nb;
        bit got;
        Reset = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0; cin = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_sum",  {16'd0, Sum}, 32'd0);
        chk("reset_cout", {31'd0, Cout}, 32'd0);
        chk("reset_ovf",  {31'd0, ovf},  32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        Reset = 1'b0;

        // Start accepted on the first edge after reset release.
        run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_posovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("add_cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("sub_neg",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_pos",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Operand / start toggles during RUN must not disturb the result.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        exp_q.push_back({16'h5555, 1'b0, 1'b0});
        @(posedge Clk);
        @(negedge Clk);
        A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        wait_done(nb, got);
        chk("toggle_done_seen", {31'd0, got}, 32'd1);
        @(negedge Clk);

        // Reset two edges into RUN aborts the operation with no done pulse.
        issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("midrun_busy", {31'd0, busy}, 32'd1);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("abort_sum",  {16'd0, Sum}, 32'd0);
        chk("abort_cout", {31'd0, Cout}, 32'd0);
        chk("abort_ovf",  {31'd0, ovf},  32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        Reset = 1'b0;
        run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        @(negedge Clk);
        chk("idle_hold_sum", {16'd0, Sum}, 32'h0002);
        chk("idle_hold_done", {31'd0, done}, 32'd0);

        // Back-to-back: start held through DONE, new operands accepted there.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        exp_q.push_back({16'h5555, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        chk("b2b_first_done", {31'd0, done}, 32'd1);
        A = 16'h0001; B = 16'h0002; cin = 1'b0; sub = 1'b0;
        exp_q.push_back({16'h0003, 1'b0, 1'b0});
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        chk("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done_dropped", {31'd0, done}, 32'd0);
        wait_done(nb, got);
        chk("b2b_second_done_seen", {31'd0, got}, 32'd1);
        chk("b2b_second_latency", nb, 32'd4);

        repeat (4) @(negedge Clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
